// File: rtl/tdm_demux.sv
// tdm_demux: TDM receive demultiplexer with SOF alignment and framing checks.
// Ports: clk, rst (async, active-high); in_valid/in_sof/in_data serial input;
//   out_data (NUM_CH*DW, channel k at [k*DW +: DW]), out_valid (per-channel
//   strobe), ch_idx (next slot), locked, frame_done, frame_err.
// Option: define TDM_DEMUX_FRAME_LATCH_EN to present whole frames at once
//   from a shadow buffer instead of updating channels slot by slot.
module tdm_demux #(
   parameter int NUM_CH = 4,
   parameter int DW     = 8,
   localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [DW-1:0]        in_data,
   output logic [NUM_CH*DW-1:0] out_data,
   output logic [NUM_CH-1:0]    out_valid,
   output logic [CW-1:0]        ch_idx,
   output logic                 locked,
   output logic                 frame_done,
   output logic                 frame_err
);

   localparam logic [0:0] S_HUNT   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

   logic [0:0]           state_q, state_d;
   logic [CW-1:0]        idx_q, idx_d;
   logic [NUM_CH*DW-1:0] data_q, data_d;
   logic [NUM_CH-1:0]    vld_q, vld_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 wr;
   logic [CW-1:0]        widx;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   logic [NUM_CH*DW-1:0] shadow_q, shadow_d;
`endif

   // Slot decision: which channel (if any) this sample lands in
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr      = 1'b0;
      widx    = '0;
      if (in_valid) begin
         if (state_q == S_HUNT) begin
            if (in_sof) begin
               wr      = 1'b1;
               idx_d   = CW'(1);
               state_d = S_LOCKED;
            end
         end else if (in_sof && idx_q != '0) begin
            // short frame: re-align on this SOF
            err_d = 1'b1;
            wr    = 1'b1;
            idx_d = CW'(1);
         end else if (!in_sof && idx_q == '0) begin
            // expected SOF never came: drop sample, lose lock
            err_d   = 1'b1;
            state_d = S_HUNT;
         end else begin
            wr   = 1'b1;
            widx = idx_q;
            if (idx_q == LAST) begin
               idx_d  = '0;
               done_d = 1'b1;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
      end
   end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   // Fill the shadow; publish it whole when the last slot arrives
   always_comb begin
      shadow_d = shadow_q;
      data_d   = data_q;
      vld_d    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (wr && widx == CW'(k)) begin
            shadow_d[k*DW +: DW] = in_data;
         end
      end
      if (done_d) begin
         data_d = shadow_d;
         vld_d  = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) shadow_q <= '0;
      else     shadow_q <= shadow_d;
   end
`else
   always_comb begin
      data_d = data_q;
      vld_d  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (wr && widx == CW'(k)) begin
            data_d[k*DW +: DW] = in_data;
            vld_d[k]           = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HUNT;
         idx_q   <= '0;
         data_q  <= '0;
         vld_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = vld_q;
   assign ch_idx     = idx_q;
   assign locked     = (state_q == S_LOCKED);
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule
